xor_stream_checksum: RTL and testbench

//   Parametrised XOR checksum engine: accumulates the bitwise XOR of all

---
 rtl/xor_stream_checksum.sv | 122 ++++++++++++
 tb/tb_xor_stream_checksum.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_checksum.sv
// Streaming XOR checksum: folds every WIDTH-bit beat of a packet into one registered result word.
// Optional macro XOR_STREAM_PARITY_EN adds out_parity (= ^out_sum), registered alongside out_sum.
module xor_stream_checksum #(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [WIDTH-1:0]                     in_data,
   input  logic                                 in_last,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [WIDTH-1:0]                     out_sum,
   output logic [$clog2(MAX_BEATS+1)-1:0]       out_beats,
`ifdef XOR_STREAM_PARITY_EN
   output logic                                 out_parity,
`endif
   output logic                                 out_ovf
);

   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_out_sum;
   logic [CNT_W-1:0]   r_out_beats;
   logic               r_out_ovf;
`ifdef XOR_STREAM_PARITY_EN
   logic               r_out_parity;
`endif

   logic               w_pending;
   logic               w_accept;
   logic               w_close;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic [WIDTH-1:0]   w_sum_nxt;

   assign w_pending = (r_state == ST_HOLD);
   assign in_ready  = !w_pending | out_ready;
   assign w_accept  = in_valid & in_ready;
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_sum_nxt = r_acc ^ in_data;
   // Reaching MAX_BEATS closes the packet even without in_last (overflow).
   assign w_close   = w_accept & (in_last | (w_cnt_inc == CNT_W'(MAX_BEATS)));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ACCUM: begin
            if (w_close) w_state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            if (w_close)        w_state_nxt = ST_HOLD;
            else if (out_ready) w_state_nxt = ST_ACCUM;
         end
         default: w_state_nxt = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // The accumulator is already clear in HOLD, so a beat accepted during the
   // output handshake simply starts the next packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_close) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_sum_nxt;
         r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_sum   <= '0;
         r_out_beats <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_close) begin
         r_out_sum   <= w_sum_nxt;
         r_out_beats <= w_cnt_inc;
         r_out_ovf   <= !in_last;
      end
   end

`ifdef XOR_STREAM_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_parity <= 1'b0;
      end else if (w_close) begin
         r_out_parity <= ^w_sum_nxt;
      end
   end

   assign out_parity = r_out_parity;
`endif

   assign out_valid = w_pending;
   assign out_sum   = r_out_sum;
   assign out_beats = r_out_beats;
   assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_xor_stream_checksum.sv
// Directed bench for xor_stream_checksum (WIDTH=8, MAX_BEATS=16); checks parity when XOR_STREAM_PARITY_EN is defined.
module tb_xor_stream_checksum;

   localparam int WIDTH     = 8;
   localparam int MAX_BEATS = 16;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_sum;
   logic [CNT_W-1:0]   out_beats;
   logic               out_ovf;
`ifdef XOR_STREAM_PARITY_EN
   logic               out_parity;
`endif

   int checks   = 0;
   int failures = 0;

   xor_stream_checksum #(
      .WIDTH     (WIDTH),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_beats  (out_beats),
`ifdef XOR_STREAM_PARITY_EN
      .out_parity (out_parity),
`endif
      .out_ovf    (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic [7:0] sum, input int beats, input logic ovf);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum"},   32'(out_sum),   32'(sum));
      chk({tag, "_beats"}, 32'(out_beats), 32'(beats));
      chk({tag, "_ovf"},   32'(out_ovf),   32'(ovf));
   endtask

   task automatic beat(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      in_last   = 1'b0;
      out_ready = 1'b0;

      // 1: reset held for 3 clocks
      repeat (3) tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",   32'(out_sum),   32'd0);
      chk("rst_beats", 32'(out_beats), 32'd0);
      chk("rst_ovf",   32'(out_ovf),   32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);
`ifdef XOR_STREAM_PARITY_EN
      chk("rst_par",   32'(out_parity), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // 2: three-beat packet 5A ^ 3C ^ FF = 99
      out_ready = 1'b1;
      beat(8'h5A, 1'b0);
      chk("t2_mid_valid", 32'(out_valid), 32'd0);
      beat(8'h3C, 1'b0);
      beat(8'hFF, 1'b1);
      idle();
      chk_result("t2", 8'h99, 3, 1'b0);
`ifdef XOR_STREAM_PARITY_EN
      chk("t2_par", 32'(out_parity), 32'd0);
`endif
      tick();
      chk("t2_drop", 32'(out_valid), 32'd0);

      // 3: backpressure for 5 clocks; a presented beat must be ignored
      out_ready = 1'b0;
      beat(8'h12, 1'b1);
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_ready", 32'(in_ready), 32'd0);
         chk_result("t3_hold", 8'h12, 1, 1'b0);
         tick();
      end
      idle();
      out_ready = 1'b1;
      #1;
      chk("t3_release_ready", 32'(in_ready), 32'd1);
      tick();
      chk("t3_drop", 32'(out_valid), 32'd0);
      chk("t3_sum_kept", 32'(out_sum), 32'h12);

      // 4: 17 beats of 01, last on 17th -> forced close at 16 then 1-beat packet
      for (int i = 0; i < 16; i++) beat(8'h01, 1'b0);
      idle();
      chk_result("t4_r1", 8'h00, 16, 1'b1);
      beat(8'h01, 1'b1);
      idle();
      chk_result("t4_r2", 8'h01, 1, 1'b0);
`ifdef XOR_STREAM_PARITY_EN
      chk("t4_par", 32'(out_parity), 32'd1);
`endif
      tick();
      chk("t4_drop", 32'(out_valid), 32'd0);

      // 5: back-to-back single-beat packets
      beat(8'hA5, 1'b1);
      chk_result("t5_a", 8'hA5, 1, 1'b0);
      beat(8'h0F, 1'b1);
      chk_result("t5_b", 8'h0F, 1, 1'b0);
      beat(8'hF0, 1'b1);
      chk_result("t5_c", 8'hF0, 1, 1'b0);
      idle();
      tick();
      chk("t5_drop", 32'(out_valid), 32'd0);

      // 7: non-closing beat accepted during output handshake starts a new packet
      out_ready = 1'b0;
      beat(8'h3C, 1'b1);
      chk_result("t7_pend", 8'h3C, 1, 1'b0);
      out_ready = 1'b1;
      beat(8'h0F, 1'b0);
      chk("t7_drop", 32'(out_valid), 32'd0);
      beat(8'hF1, 1'b1);
      idle();
      chk_result("t7_r", 8'hFE, 2, 1'b0);
      tick();

      // 6: async reset mid-packet discards partial data
      beat(8'h33, 1'b0);
      beat(8'h44, 1'b0);
      idle();
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_sum",   32'(out_sum),   32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      beat(8'h11, 1'b1);
      idle();
      chk_result("t6", 8'h11, 1, 1'b0);
`ifdef XOR_STREAM_PARITY_EN
      chk("t6_par", 32'(out_parity), 32'd0);
`endif
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
